tt_selftest_seq: RTL and testbench
==================================

// Module: tt_selftest_seq
// PURPOSE
//   Parametrised on-chip self-test sequencer for a Tiny Tapeout user project.
//   On start: pulses DUT reset, drives LFSR pseudo-random stimulus for a
//   programmable number of cycles, and compacts the DUT response into a MISR
//   signature. Compares the signature against an expected value and reports
//   pass/fail. Sits between the tt_um_* top and the user core.
// PARAMETERS
//   IN_W     8       stimulus width (1..16), driven to DUT ui_in/uio_in
//   RESP_W   8       response width (1..16), sampled from DUT uo_out
//   CNT_W    16      run-length counter width
//   PIPE_LAT 1       DUT response latency in cycles (0..7)
//   RST_CYC  4       DUT reset pulse length in cycles (>=1)
//   SEED     16'hACE1 LFSR seed (must be nonzero)
// PORTS
//   clk         in   1        clock
//   rst         in   1        async active-high reset
//   start       in   1        begin test; sampled in IDLE only
//   len         in   CNT_W    stimulus cycles; latched on accepted start
//   expect_sig  in   16       golden signature; latched on accepted start
//   resp        in   RESP_W   DUT response
//   stim        out  IN_W     stimulus to DUT
//   stim_valid  out  1        high in RUN cycles
//   dut_rst     out  1        active-high reset to DUT
//   busy        out  1        high in any state except IDLE
//   done        out  1        one-cycle pulse at end of test
//   pass        out  1        sig==expect_sig; valid from done until next start
//   sig         out  16       MISR signature; holds after done
//   abort       in   1        only with TT_SELFTEST_ABORT_EN
// BEHAVIOUR
//   Reset (async, rst=1):
//   - all outputs 0; LFSR=SEED; MISR=0; FSM=IDLE.
//   FSM: IDLE -> DRST -> RUN -> DRAIN -> FIN -> IDLE.
//   - IDLE: start=1 latches len and expect_sig, clears MISR, reloads LFSR=SEED, clears pass.
//   - DRST: dut_rst=1 for exactly RST_CYC cycles.
//     -> RUN if len!=0, else -> DRAIN.
//   - RUN: len cycles. stim=lfsr[IN_W-1:0], stim_valid=1; LFSR steps every RUN cycle.
//   - DRAIN: PIPE_LAT cycles; stim=0, stim_valid=0.
//   - FIN: done=1 and pass=(MISR==expect_sig), one cycle; -> IDLE.
//   Capture:
//   - stim_valid delayed through a PIPE_LAT-deep shift register gates MISR updates.
//   - Exactly len responses are folded in: the samples taken PIPE_LAT cycles after each RUN cycle.
//   LFSR / MISR:
//   - 16-bit Galois, polynomial 16'hB400. step(x) = (x>>1) ^ (x[0] ? 16'hB400 : 0).
//   - MISR_next = step(MISR) ^ {zero-ext resp}.
//   Latency:
//   - done asserts RST_CYC+len+PIPE_LAT+1 cycles after the start edge.
//   Boundaries:
//   - start while busy: ignored.
//   - len changes mid-run: no effect.
//   - len=0: no stimulus; sig=0.
//   - len=2^CNT_W-1: counter must not wrap early.
//   - rst mid-test: immediate return to IDLE; dut_rst drops; no done pulse.
// CONFIGURATION
//   TT_SELFTEST_ABORT_EN defined:
//   - abort=1 in any busy state -> IDLE next cycle; done=0, pass=0, sig holds partial MISR.
//   - abort has priority over FSM transitions; abort in IDLE is ignored.
//   Undefined: no abort port; the test always runs to FIN.
// STRUCTURE
//   Package tt_selftest_pkg:
//   - state enum (IDLE, DRST, RUN, DRAIN, FIN)
//   - POLY=16'hB400
//   - function lfsr_step
//   Sub-module tt_lfsr16:
//   - 16-bit register with load, step and xor-in ports
//   - instanced twice: stimulus LFSR (xor-in 0) and MISR (xor-in resp).
// TESTING
//   1 Reset: rst=1 mid-RUN -> next edge busy=0, dut_rst=0, stim=0; no done.
//   2 len=0, expect=16'h0000: done after RST_CYC+PIPE_LAT+1=6 cycles, pass=1, sig=0.
//   3 Loopback resp=stim, len=256: first stim=8'hE1, stim_valid high exactly 256 cycles,
//     sig equals bench model; pass=1 with model sig, pass=0 with sig^1.
//   4 PIPE_LAT=3, delayed loopback: identical sig to scenario 3 at PIPE_LAT=0.
//   5 start pulsed during RUN, len changed: ignored; cycle count and sig unchanged.
//   6 ABORT_EN: abort at RUN cycle 10 -> IDLE next cycle, done never pulses.
//     A new start then gives the full-length result.

Source files
------------

// File: rtl/tt_selftest_pkg.sv
// Shared types and LFSR arithmetic for the Tiny Tapeout self-test sequencer.
package tt_selftest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRST  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  localparam logic [15:0] POLY = 16'hB400;

  // Galois right-shift step, shared by the stimulus LFSR and the MISR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/tt_lfsr16.sv
// 16-bit Galois register with synchronous load and step; xin is folded in on
// every step, so it serves as a plain LFSR (xin=0) or as a MISR.
module tt_lfsr16
  import tt_selftest_pkg::*;
#(
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        step,
  input  logic [15:0] xin,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (step) begin
      q <= lfsr_step(q) ^ xin;
    end
  end

endmodule

// File: rtl/tt_selftest_seq.sv
// Self-test sequencer: resets the user core, drives LFSR stimulus, compacts the
// response into a MISR and compares it to a golden signature. TT_SELFTEST_ABORT_EN adds abort.
module tt_selftest_seq
  import tt_selftest_pkg::*;
#(
  parameter int          IN_W     = 8,
  parameter int          RESP_W   = 8,
  parameter int          CNT_W    = 16,
  parameter int          PIPE_LAT = 1,
  parameter int          RST_CYC  = 4,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [15:0]       expect_sig,
  input  logic [RESP_W-1:0] resp,
`ifdef TT_SELFTEST_ABORT_EN
  input  logic              abort,
`endif
  output logic [IN_W-1:0]   stim,
  output logic              stim_valid,
  output logic              dut_rst,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       sig,
  output state_t            state_dbg
);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_ld_val;
  logic              cnt_ld;
  logic [CNT_W-1:0]  len_q;
  logic [15:0]       exp_q;
  logic              accept, fin_go, abort_go, cap_en;
  logic [15:0]       lfsr_q, misr_q;
  logic              lfsr_unused;

`ifdef TT_SELFTEST_ABORT_EN
  assign abort_go = abort && (state != ST_IDLE);
`else
  assign abort_go = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Each phase loads cnt with (length-1) on entry and leaves when it reaches 0,
  // so a full-scale len never wraps; zero-length phases are skipped entirely.
  always_comb begin
    state_d    = state;
    cnt_ld     = 1'b0;
    cnt_ld_val = '0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_d    = ST_DRST;
          cnt_ld     = 1'b1;
          cnt_ld_val = CNT_W'(RST_CYC - 1);
        end
      end
      ST_DRST: begin
        if (cnt == '0) begin
          if (len_q != '0) begin
            state_d    = ST_RUN;
            cnt_ld     = 1'b1;
            cnt_ld_val = len_q - CNT_W'(1);
          end else if (PIPE_LAT > 0) begin
            state_d    = ST_DRAIN;
            cnt_ld     = 1'b1;
            cnt_ld_val = CNT_W'(PIPE_LAT) - CNT_W'(1);
          end else begin
            state_d    = ST_FIN;
          end
        end
      end
      ST_RUN: begin
        if (cnt == '0) begin
          if (PIPE_LAT > 0) begin
            state_d    = ST_DRAIN;
            cnt_ld     = 1'b1;
            cnt_ld_val = CNT_W'(PIPE_LAT) - CNT_W'(1);
          end else begin
            state_d    = ST_FIN;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt == '0) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_go) begin
      state_d = ST_IDLE;
      cnt_ld  = 1'b0;
    end
  end

  assign fin_go = (state == ST_FIN) && !abort_go;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      len_q <= '0;
      exp_q <= '0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      done <= fin_go;
      if (cnt_ld)          cnt <= cnt_ld_val;
      else if (cnt != '0)  cnt <= cnt - CNT_W'(1);
      if (accept) begin
        len_q <= len;
        exp_q <= expect_sig;
        pass  <= 1'b0;
      end else if (fin_go) begin
        pass <= (misr_q == exp_q);
      end else if (abort_go) begin
        pass <= 1'b0;
      end
    end
  end

  // Capture enable is stim_valid aligned to the DUT's response latency.
  generate
    if (PIPE_LAT == 0) begin : g_nopipe
      assign cap_en = stim_valid;
    end else begin : g_pipe
      logic [PIPE_LAT-1:0] vpipe;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vpipe <= '0;
        end else if (accept) begin
          vpipe <= '0;
        end else begin
          vpipe[0] <= stim_valid;
          for (int i = 1; i < PIPE_LAT; i++) vpipe[i] <= vpipe[i-1];
        end
      end
      assign cap_en = vpipe[PIPE_LAT-1];
    end
  endgenerate

  tt_lfsr16 #(.RST_VAL(SEED)) u_stim_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (SEED),
    .step     (stim_valid),
    .xin      (16'h0000),
    .q        (lfsr_q)
  );

  tt_lfsr16 #(.RST_VAL(16'h0000)) u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (16'h0000),
    .step     (cap_en && busy),
    .xin      (16'(resp)),
    .q        (misr_q)
  );

  assign lfsr_unused = ^(lfsr_q >> IN_W);

  assign stim_valid = (state == ST_RUN);
  assign stim       = stim_valid ? lfsr_q[IN_W-1:0] : '0;
  assign dut_rst    = (state == ST_DRST);
  assign busy       = (state != ST_IDLE);
  assign sig        = misr_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_tt_selftest_seq.sv
// Directed bench for tt_selftest_seq: PIPE_LAT=1 and PIPE_LAT=3 instances share
// stimulus with delayed loopback; a CNT_W=4 instance covers the full-scale length.
module tb_tt_selftest_seq;
  import tt_selftest_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, start4, abort;
  logic [15:0] len, expect_sig, expect4;
  logic [3:0]  len4;
  logic [7:0]  resp1, resp3, resp4, p3a, p3b;
  logic [7:0]  stim1, stim3, stim4;
  logic        sv1, sv3, sv4, drst1, drst3, drst4, busy1, busy3, busy4;
  logic        done1, done3, done4, pass1, pass3, pass4;
  logic [15:0] sig1, sig3, sig4;
  state_t      st1, st3, st4;

  int n_checks = 0;
  int n_pass   = 0;
  int dc1, dc3, dc4, nvalid, nvalid4, nrst, ndone1, nd;
  logic [7:0]  first_stim;
  logic [15:0] m;

  always #5 clk = ~clk;

  tt_selftest_seq #(.PIPE_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .expect_sig(expect_sig), .resp(resp1),
`ifdef TT_SELFTEST_ABORT_EN
    .abort(abort),
`endif
    .stim(stim1), .stim_valid(sv1), .dut_rst(drst1), .busy(busy1), .done(done1),
    .pass(pass1), .sig(sig1), .state_dbg(st1)
  );

  tt_selftest_seq #(.PIPE_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .len(len), .expect_sig(expect_sig), .resp(resp3),
`ifdef TT_SELFTEST_ABORT_EN
    .abort(abort),
`endif
    .stim(stim3), .stim_valid(sv3), .dut_rst(drst3), .busy(busy3), .done(done3),
    .pass(pass3), .sig(sig3), .state_dbg(st3)
  );

  tt_selftest_seq #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .len(len4), .expect_sig(expect4), .resp(resp4),
`ifdef TT_SELFTEST_ABORT_EN
    .abort(1'b0),
`endif
    .stim(stim4), .stim_valid(sv4), .dut_rst(drst4), .busy(busy4), .done(done4),
    .pass(pass4), .sig(sig4), .state_dbg(st4)
  );

  // Loopback user cores with 1- and 3-cycle registered latency.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      resp1 <= '0; resp4 <= '0; p3a <= '0; p3b <= '0; resp3 <= '0;
    end else begin
      resp1 <= stim1;
      resp4 <= stim4;
      p3a   <= stim3;
      p3b   <= p3a;
      resp3 <= p3b;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) $display("FAIL %s: got %0h want %0h", tag, got, want);
    else n_pass++;
  endtask

  function automatic logic [15:0] step16(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] model_sig(input int n);
    logic [15:0] l = 16'hACE1;
    logic [15:0] s = 16'h0000;
    for (int i = 0; i < n; i++) begin
      s = step16(s) ^ {8'h00, l[7:0]};
      l = step16(l);
    end
    return s;
  endfunction

  // Cycle 0 is the negedge right after the start edge; poke<0 means no mid-run start.
  task automatic run_pair(input logic [15:0] l, input logic [15:0] e, input int poke);
    int  cyc;
    bit  got_first;
    dc1 = 0; dc3 = 0; nvalid = 0; nrst = 0; ndone1 = 0; first_stim = '0; got_first = 0;
    @(negedge clk);
    len = l; expect_sig = e; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while ((dc1 == 0 || dc3 == 0) && cyc < 2000) begin
      if (done1) begin ndone1++; if (dc1 == 0) dc1 = cyc; end
      if (done3 && dc3 == 0) dc3 = cyc;
      if (sv1) begin
        nvalid++;
        if (!got_first) begin first_stim = stim1; got_first = 1; end
      end
      if (drst1) nrst++;
      if (cyc == poke) begin start = 1'b1; len = l ^ 16'h0005; end
      else if (cyc == poke + 1) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_small(input logic [3:0] l, input logic [15:0] e);
    int cyc;
    dc4 = 0; nvalid4 = 0;
    @(negedge clk);
    len4 = l; expect4 = e; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    cyc = 0;
    while (dc4 == 0 && cyc < 500) begin
      if (done4) dc4 = cyc;
      if (sv4) nvalid4++;
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start4 = 1'b0; abort = 1'b0;
    len = '0; len4 = '0; expect_sig = '0; expect4 = '0;
    #1;
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_pass", pass1, 0);
    check("rst_sig", sig1, 0);
    check("rst_stim", {sv1, stim1}, 0);
    check("rst_dut_rst", drst1, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // len=0: only reset pulse and drain
    run_pair(16'd0, 16'h0000, -1);
    check("len0_done_cyc", dc1, 6);
    check("len0_done_cyc_lat3", dc3, 8);
    check("len0_dut_rst_cycles", nrst, 4);
    check("len0_stim_cycles", nvalid, 0);
    check("len0_sig", sig1, 16'h0000);
    check("len0_pass", pass1, 1);
    check("len0_pass_lat3", pass3, 1);

    // len=2: 0x00E1 then step(0x00E1)^0x70 = 0xB400
    run_pair(16'd2, 16'hB400, -1);
    check("len2_done_cyc", dc1, 8);
    check("len2_sig", sig1, 16'hB400);
    check("len2_sig_lat3", sig3, 16'hB400);
    check("len2_pass", pass1, 1);

    m = model_sig(256);
    run_pair(16'd256, m, -1);
    check("len256_first_stim", first_stim, 8'hE1);
    check("len256_stim_cycles", nvalid, 256);
    check("len256_done_cyc", dc1, 262);
    check("len256_done_cyc_lat3", dc3, 264);
    check("len256_done_width", ndone1, 1);
    check("len256_sig", sig1, m);
    check("len256_sig_lat3", sig3, m);
    check("len256_pass", pass1, 1);
    check("len256_pass_lat3", pass3, 1);
    repeat (5) @(negedge clk);
    check("len256_pass_hold", pass1, 1);
    check("len256_sig_hold", sig1, m);

    run_pair(16'd256, m ^ 16'h0001, -1);
    check("len256_bad_pass", pass1, 0);
    check("len256_bad_pass_lat3", pass3, 0);
    check("len256_bad_sig", sig1, m);

    // start and len poked mid-RUN must be ignored
    m = model_sig(20);
    run_pair(16'd20, m, 10);
    check("poke_done_cyc", dc1, 26);
    check("poke_stim_cycles", nvalid, 20);
    check("poke_sig", sig1, m);
    check("poke_pass", pass1, 1);

    // async reset in the middle of RUN
    @(negedge clk);
    len = 16'd50; expect_sig = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_pre_busy", busy1, 1);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy1, 0);
    check("midrst_dut_rst", drst1, 0);
    check("midrst_stim", {sv1, stim1}, 0);
    @(posedge clk);
    #1;
    check("midrst_busy_edge", {busy1, busy3}, 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (70) begin
      @(negedge clk);
      if (done1 || done3) nd++;
    end
    check("midrst_no_done", nd, 0);

    // full-scale length on the 4-bit counter instance
    m = model_sig(15);
    run_small(4'd15, m);
    check("len15_done_cyc", dc4, 21);
    check("len15_stim_cycles", nvalid4, 15);
    check("len15_sig", sig4, m);
    check("len15_pass", pass4, 1);

`ifdef TT_SELFTEST_ABORT_EN
    @(negedge clk);
    len = 16'd40; expect_sig = model_sig(40); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("abort_pre_run", sv1, 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", {busy1, busy3}, 0);
    nd = 0;
    repeat (60) begin
      @(negedge clk);
      if (done1 || done3) nd++;
    end
    check("abort_no_done", nd, 0);
    check("abort_pass", pass1, 0);
    check("abort_partial_sig", sig1, model_sig(10));
    check("abort_partial_sig_lat3", sig3, model_sig(8));
    m = model_sig(40);
    run_pair(16'd40, m, -1);
    check("after_abort_done_cyc", dc1, 46);
    check("after_abort_sig", sig1, m);
    check("after_abort_pass", pass1, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
